mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port Clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports cpu_req / dbg_req  in  1  access request from the CPU datapath / debug (switch-load) port.
REQ-004 SHALL have ports cpu_we / dbg_we  in  1  1 = write, 0 = read; sampled with the request.
REQ-005 SHALL have ports cpu_addr / dbg_addr  in  16  word address.
REQ-006 SHALL have ports cpu_wdata / dbg_wdata  in  16  write data.
REQ-007 SHALL have ports cpu_ack / dbg_ack  out  1  one-cycle completion pulse to the requester.
REQ-008 SHALL have port rdata  out  16  read data, valid in the ack cycle and held until the next read completes.
REQ-009 SHALL have ports Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM controls, active-low.
REQ-010 SHALL have port Mem_ADDR  out  16  SRAM address.
REQ-011 SHALL have port Mem_DOUT  out  16  data to SRAM.
REQ-012 SHALL have port Mem_DRIVE  out  1  tristate enable for Mem_DOUT; 1 = drive bus.
REQ-013 SHALL have port Mem_DIN  in  16  data from SRAM.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, RD1, RD2, WR1, WR2 and DONE.
REQ-016 IDLE: if any request is high, SHALL grant one requester and latch its we, addr and wdata into internal registers, then go to RD1 (we=0) or WR1 (we=1); otherwise SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin via a last-grant bit: when both requests are high, grant the requester not granted last; a single request SHALL be granted immediately.
REQ-018 The last-grant bit SHALL update only on a grant.
REQ-019 RD1: Mem_OE=0; next state RD2.
REQ-020 RD2: Mem_OE=0; rdata <= Mem_DIN at the end of the cycle; next state DONE.
REQ-021 WR1 and WR2: Mem_WE=0, Mem_DRIVE=1, Mem_DOUT = latched wdata; WR1 goes to WR2 and WR2 goes to DONE.
REQ-022 DONE: Mem_OE=1, Mem_WE=1, Mem_DRIVE=0; pulse the granted requester's ack for exactly one cycle; next state IDLE.
REQ-023 Mem_ADDR SHALL equal the latched address in RD1, RD2, WR1, WR2 and DONE, and 0x0000 in IDLE.
REQ-024 Mem_CE, Mem_UB and Mem_LB SHALL be 0 at all times.
REQ-025 Outside the states named in REQ-019 to REQ-021, Mem_OE=1, Mem_WE=1 and Mem_DRIVE=0.
REQ-026 Latency: from a request sampled in IDLE to ack SHALL be exactly 3 cycles (grant edge -> X1 -> X2 -> DONE); a back-to-back access SHALL take 4 cycles.
REQ-027 Requesters hold req, we, addr and wdata until ack; changes after the grant SHALL be ignored.
REQ-028 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-029 Mem_WE and Mem_DRIVE SHALL never be low/high respectively in the same cycle as Mem_OE=0.
REQ-030 At most one ack SHALL be high in any cycle.
REQ-031 Signal state: ack outputs and all memory controls SHALL be decoded combinationally from the state and latched registers only, never directly from req inputs.

Reset
REQ-032 Reset SHALL force state=IDLE, last-grant=dbg (so cpu wins the first tie), rdata=0x0000 and the latched registers to 0.
REQ-033 While in reset, outputs SHALL be: Mem_OE=1, Mem_WE=1, Mem_DRIVE=0, Mem_ADDR=0, both acks=0, busy=0.
REQ-034 Reset asserted mid-access SHALL abort the access with no ack issued and no further Mem_WE low cycle.
REQ-035 After reset deasserts, the first request SHALL be arbitrated fresh.

Verification
REQ-036 CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x0010, Mem_DIN=0xBEEF -> Mem_OE low for 2 cycles, cpu_ack on the 3rd cycle after grant, rdata=0xBEEF.
REQ-037 Debug write: dbg_req=1, dbg_we=1, dbg_addr=0x0003, dbg_wdata=0x1234 -> Mem_WE low and Mem_DRIVE high for 2 cycles with Mem_ADDR=0x0003 and Mem_DOUT=0x1234, then dbg_ack pulse.
REQ-038 Contention: cpu_req and dbg_req both held high from reset -> grants alternate cpu, dbg, cpu, dbg; each ack is spaced 4 cycles apart.
REQ-039 Abort: Reset pulsed during WR1 -> Mem_WE=1 immediately, no ack, state IDLE, busy=0.
REQ-040 Input change: cpu_addr changed from 0x0010 to 0x0020 during RD2 -> Mem_ADDR stays 0x0010 through DONE.
REQ-041 Checker: assert REQ-029 and REQ-030 on every cycle of all scenarios.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one asynchronous SRAM between the CPU datapath and the
// debug (switch-load) port. One access runs at a time through a small FSM.
// When both ports request together, a last-grant bit picks the one that was
// not served last. The chosen request's we/addr/wdata are captured at grant,
// so the requester may change its inputs afterwards without affecting the
// access. The SRAM strobes and acks come only from the state and the captured
// registers, never straight from the request inputs.
module mem_arbiter (
    input  logic        Clk,
    input  logic        Reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,

    output logic [15:0] rdata,

    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [15:0] Mem_ADDR,
    output logic [15:0] Mem_DOUT,
    output logic        Mem_DRIVE,
    input  logic [15:0] Mem_DIN,

    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Requester encoding for the last-grant bit.
    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DBG = 1'b1;

    state_t      state_reg;
    logic        last_grant_reg;   // requester granted most recently; also owns the access in flight
    logic        we_reg;
    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    logic [15:0] rdata_reg;

    logic        any_req;
    logic        grant_dbg;        // requester selected if a grant happens this cycle
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    // Round-robin choice: debug wins when it is the only requester, or when
    // both request and the CPU was served last.
    always_comb begin
        any_req   = cpu_req | dbg_req;
        grant_dbg = dbg_req & (~cpu_req | (last_grant_reg == GRANT_CPU));
        sel_we    = grant_dbg ? dbg_we    : cpu_we;
        sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
        sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
    end

    // Access sequencer: grant and capture in IDLE, two strobe cycles, then DONE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_DBG;   // CPU takes the first tie after reset
            we_reg         <= 1'b0;
            addr_reg       <= 16'h0000;
            wdata_reg      <= 16'h0000;
            rdata_reg      <= 16'h0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        last_grant_reg <= grant_dbg ? GRANT_DBG : GRANT_CPU;
                        we_reg         <= sel_we;
                        addr_reg       <= sel_addr;
                        wdata_reg      <= sel_wdata;
                        state_reg      <= sel_we ? WR1 : RD1;
                    end
                end
                RD1: begin
                    state_reg <= RD2;
                end
                RD2: begin
                    // Data has had a full strobe cycle to settle; capture it.
                    rdata_reg <= Mem_DIN;
                    state_reg <= DONE;
                end
                WR1: begin
                    state_reg <= WR2;
                end
                WR2: begin
                    state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // SRAM strobes, address and acks decoded from the state and captured registers.
    always_comb begin
        Mem_CE    = 1'b0;
        Mem_UB    = 1'b0;
        Mem_LB    = 1'b0;
        Mem_OE    = ~((state_reg == RD1) | (state_reg == RD2));
        Mem_WE    = ~((state_reg == WR1) | (state_reg == WR2));
        Mem_DRIVE = (state_reg == WR1) | (state_reg == WR2);
        Mem_DOUT  = wdata_reg;
        Mem_ADDR  = (state_reg == IDLE) ? 16'h0000 : addr_reg;
        cpu_ack   = (state_reg == DONE) & (last_grant_reg == GRANT_CPU);
        dbg_ack   = (state_reg == DONE) & (last_grant_reg == GRANT_DBG);
        busy      = (state_reg != IDLE);
        rdata     = rdata_reg;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives the two request ports against a behavioural SRAM
// model. Every access pushes its expected outcome onto a scoreboard; an ack
// monitor pops and compares. Bus invariants are checked on every cycle.
module tb_mem_arbiter;

    logic        clk;
    logic        Reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_ack, dbg_ack;
    logic [15:0] rdata;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_DRIVE;
    logic [15:0] Mem_ADDR, Mem_DOUT, Mem_DIN;
    logic        busy;

    mem_arbiter dut (
        .Clk       (clk),
        .Reset     (Reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .rdata     (rdata),
        .Mem_CE    (Mem_CE),
        .Mem_UB    (Mem_UB),
        .Mem_LB    (Mem_LB),
        .Mem_OE    (Mem_OE),
        .Mem_WE    (Mem_WE),
        .Mem_ADDR  (Mem_ADDR),
        .Mem_DOUT  (Mem_DOUT),
        .Mem_DRIVE (Mem_DRIVE),
        .Mem_DIN   (Mem_DIN),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: asynchronous read, write on a clock edge while strobed.
    logic [15:0] sram [0:255];
    assign Mem_DIN = sram[Mem_ADDR[7:0]];
    always @(posedge clk) begin
        if (!Mem_WE && Mem_DRIVE)
            sram[Mem_ADDR[7:0]] <= Mem_DOUT;
    end

    typedef struct packed {
        logic        who;    // 0 = cpu, 1 = dbg
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;   // read: expected rdata; write: expected memory content
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Every-cycle bus invariants, plus the scoreboard side of each ack.
    always @(negedge clk) begin
        check("invariant",
              {29'd0,
               (!Mem_OE && (!Mem_WE || Mem_DRIVE)),
               (cpu_ack && dbg_ack),
               (Mem_CE || Mem_UB || Mem_LB)},
              32'd0);
        if (cpu_ack || dbg_ack) begin
            if (sb_q.size() == 0) begin
                check("ack_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_who", {31'd0, dbg_ack}, {31'd0, mon_e.who});
                check("ack_addr", {16'd0, Mem_ADDR}, {16'd0, mon_e.addr});
                if (mon_e.we)
                    check("wr_mem", {16'd0, sram[mon_e.addr[7:0]]}, {16'd0, mon_e.data});
                else
                    check("rdata", {16'd0, rdata}, {16'd0, mon_e.data});
                $display("txn %s %s addr=0x%04h data=0x%04h",
                         mon_e.who ? "dbg" : "cpu", mon_e.we ? "wr" : "rd",
                         mon_e.addr, mon_e.we ? sram[mon_e.addr[7:0]] : rdata);
            end
        end
    end

    // One single-requester access: push expectation, hold request until ack,
    // measure latency and strobe cycles. chg alters the held address in RD2/WR2.
    task automatic access(input logic who, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic chg);
        exp_t e;
        int   n;
        int   oe_lo;
        int   we_lo;
        logic got;
        e.who  = who;
        e.we   = we;
        e.addr = addr;
        e.data = we ? wdata : sram[addr[7:0]];
        sb_q.push_back(e);
        if (!who) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end
        n = 0; oe_lo = 0; we_lo = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (!Mem_OE && Mem_ADDR == addr) oe_lo++;
            if (!Mem_WE && Mem_DRIVE && Mem_DOUT == wdata && Mem_ADDR == addr) we_lo++;
            if (who ? dbg_ack : cpu_ack) got = 1'b1;
            if (chg && n == 2) begin
                if (!who) cpu_addr = addr + 16'h0010;
                else      dbg_addr = addr + 16'h0010;
            end
        end
        check("ack_latency", 32'(n), 32'd3);
        if (we) check("we_cycles", 32'(we_lo), 32'd2);
        else    check("oe_cycles", 32'(oe_lo), 32'd2);
        if (!who) cpu_req = 1'b0;
        else      dbg_req = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", {30'd0, cpu_ack, dbg_ack}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
        sram[8'h10] = 16'hBEEF;
        Reset   = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0000; dbg_wdata = 16'h0000;

        // Reset state.
        #1;
        check("rst_ctrl", {29'd0, Mem_OE, Mem_WE, Mem_DRIVE}, 32'b110);
        check("rst_addr", {16'd0, Mem_ADDR}, 32'd0);
        check("rst_ack_busy", {29'd0, cpu_ack, dbg_ack, busy}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);

        // CPU read; address changed mid-access must be ignored.
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1);
        check("cpu_read_beef", {16'd0, rdata}, 32'h0000BEEF);

        // Debug write.
        access(1'b1, 1'b1, 16'h0003, 16'h1234, 1'b0);
        check("dbg_wrote", {16'd0, sram[8'h03]}, 32'h00001234);
        check("rdata_held", {16'd0, rdata}, 32'h0000BEEF);

        // A few mixed accesses.
        sram[8'h44] = 16'hC0DE;
        access(1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0);
        access(1'b0, 1'b1, 16'h0055, 16'hA5A5, 1'b1);
        access(1'b0, 1'b0, 16'h0055, 16'h0000, 1'b0);

        // Abort: reset during WR1 of a debug write.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0003; dbg_wdata = 16'hDEAD;
        @(negedge clk);
        check("abort_in_wr1", {30'd0, Mem_WE, Mem_DRIVE}, 32'b01);
        Reset = 1'b1;
        #1;
        check("abort_ctrl", {29'd0, Mem_OE, Mem_WE, Mem_DRIVE}, 32'b110);
        check("abort_busy_ack", {29'd0, busy, cpu_ack, dbg_ack}, 32'd0);
        check("abort_addr", {16'd0, Mem_ADDR}, 32'd0);
        check("abort_rdata", {16'd0, rdata}, 32'd0);
        dbg_req = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_write", {16'd0, sram[8'h03]}, 32'h00001234);

        // CPU write so the last grant is CPU before the contention reset.
        access(1'b0, 1'b1, 16'h0020, 16'h5A5A, 1'b0);

        // Contention from reset: grants must alternate cpu, dbg, cpu, dbg.
        Reset   = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.who  = k[0];
            e.we   = 1'b0;
            e.addr = k[0] ? 16'h0020 : 16'h0010;
            e.data = k[0] ? 16'h5A5A : 16'hBEEF;
            sb_q.push_back(e);
        end
        @(negedge clk);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(cpu_ack || dbg_ack) && n < 20);
            check("ack_spacing", 32'(n), (k == 0) ? 32'd3 : 32'd4);
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("end_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
